// File: rtl/led_pattern_sequencer.sv
// Four-LED pattern controller: shared tick prescaler, OFF/BLINK/CHASE/ALL_ON mode FSM.
// Define DEBOUNCE_EN to insert a per-switch stability filter after the synchronizers.
module led_pattern_sequencer #(
  parameter int g_CLKS_PER_TICK = 1250000,
  parameter int g_DEBOUNCE_CLKS = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int PW = $clog2(g_CLKS_PER_TICK);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_ALL_ON = 2'd3
  } mode_t;

  mode_t         mode;
  logic [PW-1:0] presc;
  logic [3:0]    tick_idx;
  logic [3:0]    leds;
  logic [1:0]    sw_s1;
  logic [1:0]    sw_s2;
  logic [1:0]    filt;
  logic          filt1_prev;
  logic          press;
  logic          pause;
  logic          tick;

  // Bit 0 carries switch 1, bit 1 carries switch 2.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so s1->s2 is a real two-stage chain.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= {i_Switch_2, i_Switch_1};
      sw_s2 <= sw_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = (g_DEBOUNCE_CLKS > 1) ? $clog2(g_DEBOUNCE_CLKS) : 1;
  logic [DW-1:0] db_cnt [2];

  // A switch must disagree with its filtered level for g_DEBOUNCE_CLKS clocks before the level flips.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sw_s2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(g_DEBOUNCE_CLKS - 1)) begin
          filt[i]   <= sw_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = sw_s2;
`endif

  assign press = filt[0] & ~filt1_prev;
  assign pause = filt[1];
  assign tick  = (presc == PW'(g_CLKS_PER_TICK - 1)) & ~pause;

  // A press outranks a same-cycle tick: the tick is dropped and the new mode starts from its entry value.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      mode       <= MODE_OFF;
      presc      <= '0;
      tick_idx   <= '0;
      leds       <= '0;
      filt1_prev <= 1'b0;
    end else begin
      filt1_prev <= filt[0];
      if (press) begin
        presc    <= '0;
        tick_idx <= '0;
        unique case (mode)
          MODE_OFF:    begin mode <= MODE_BLINK;  leds <= 4'b0000; end
          MODE_BLINK:  begin mode <= MODE_CHASE;  leds <= 4'b0001; end
          MODE_CHASE:  begin mode <= MODE_ALL_ON; leds <= 4'b1111; end
          MODE_ALL_ON: begin mode <= MODE_OFF;    leds <= 4'b0000; end
          default:     begin mode <= MODE_OFF;    leds <= 4'b0000; end
        endcase
      end else if (!pause) begin
        if (tick) begin
          presc    <= '0;
          tick_idx <= (tick_idx == 4'd9) ? 4'd0 : tick_idx + 4'd1;
          case (mode)
            MODE_BLINK: leds <= leds ^ {tick_idx == 4'd9,
                                        (tick_idx == 4'd4) || (tick_idx == 4'd9),
                                        tick_idx[0],
                                        1'b1};
            MODE_CHASE: if (tick_idx[0]) leds <= {leds[2:0], leds[3]};
            default:    leds <= leds;
          endcase
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign o_LED_1 = leds[0];
  assign o_LED_2 = leds[1];
  assign o_LED_3 = leds[2];
  assign o_LED_4 = leds[3];
  assign o_Mode  = mode;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed steps plus random switch activity against a tick-count model.
module tb_led_pattern_sequencer;

  localparam int N = 4;
  localparam int G = 3;

  logic       i_Clk      = 1'b0;
  logic       i_Rst_L    = 1'b0;
  logic       i_Switch_1 = 1'b0;
  logic       i_Switch_2 = 1'b0;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [1:0] o_Mode;

  int compared   = 0;
  int mismatched = 0;

  always #5 i_Clk = ~i_Clk;

  led_pattern_sequencer #(
    .g_CLKS_PER_TICK(N),
    .g_DEBOUNCE_CLKS(G)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Switch_1(i_Switch_1),
    .i_Switch_2(i_Switch_2),
    .o_LED_1   (o_LED_1),
    .o_LED_2   (o_LED_2),
    .o_LED_3   (o_LED_3),
    .o_LED_4   (o_LED_4),
    .o_Mode    (o_Mode)
  );

  // Reference model: the LED pattern is a pure function of the mode and of ticks elapsed in that mode.
  int   m_mode  = 0;
  int   m_ticks = 0;
  int   m_phase = 0;
  logic m_a1 = 0, m_a2 = 0, m_b1 = 0, m_b2 = 0, m_prev = 0;
  logic m_f1 = 0, m_f2 = 0;
  int   m_run1 = 0, m_run2 = 0;

  always @(posedge i_Clk) begin
    logic f1, f2;
    if (!i_Rst_L) begin
      m_mode = 0; m_ticks = 0; m_phase = 0;
      m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0; m_prev = 0;
      m_f1 = 0; m_f2 = 0; m_run1 = 0; m_run2 = 0;
    end else begin
`ifdef DEBOUNCE_EN
      f1 = m_f1;
      f2 = m_f2;
`else
      f1 = m_a2;
      f2 = m_b2;
`endif
      if (f1 && !m_prev) begin
        m_mode  = (m_mode + 1) % 4;
        m_ticks = 0;
        m_phase = 0;
      end else if (!f2) begin
        if (m_phase == N - 1) begin
          m_phase = 0;
          m_ticks++;
        end else begin
          m_phase++;
        end
      end
      m_prev = f1;
`ifdef DEBOUNCE_EN
      if (m_a2 != m_f1) m_run1++; else m_run1 = 0;
      if (m_run1 >= G) begin m_f1 = m_a2; m_run1 = 0; end
      if (m_b2 != m_f2) m_run2++; else m_run2 = 0;
      if (m_run2 >= G) begin m_f2 = m_b2; m_run2 = 0; end
`endif
      m_a2 = m_a1; m_a1 = i_Switch_1;
      m_b2 = m_b1; m_b1 = i_Switch_2;
    end
  end

  function automatic logic [3:0] exp_leds(input int mode, input int ticks);
    logic [3:0] v;
    v = 4'b0000;
    case (mode)
      1: v = {1'((ticks / 10) % 2), 1'((ticks / 5) % 2), 1'((ticks / 2) % 2), 1'(ticks % 2)};
      2: v = 4'b0001 << ((ticks / 2) % 4);
      3: v = 4'b1111;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance n cycles, checking LEDs and mode on every falling edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clk);
      check("leds", {o_LED_4, o_LED_3, o_LED_2, o_LED_1}, exp_leds(m_mode, m_ticks));
      check("mode", {2'b00, o_Mode}, 4'(m_mode));
    end
  endtask

  task automatic press(input int hold, input int gap);
    i_Switch_1 = 1'b1;
    run(hold);
    i_Switch_1 = 1'b0;
    run(gap);
  endtask

  initial begin
    // Reset held for three clocks, then a long idle stretch in OFF.
    i_Rst_L = 1'b0;
    run(3);
    check("reset_leds", {o_LED_4, o_LED_3, o_LED_2, o_LED_1}, 4'b0000);
    check("reset_mode", {2'b00, o_Mode}, 4'b0000);
    i_Rst_L = 1'b1;
    run(200);

    // OFF -> BLINK, then 40 ticks of blinking.
    press(10, 6);
    run(160);

    // BLINK -> CHASE, then watch several rotations.
    press(10, 6);
    run(60);

    // Through ALL_ON and OFF back to BLINK, then pause mid-tick.
    press(10, 10);
    press(10, 10);
    press(10, 13);
    i_Switch_2 = 1'b1;
    run(50);
    i_Switch_2 = 1'b0;
    run(30);

    // Short glitch on switch 1 (filtered out only with debouncing).
    i_Switch_1 = 1'b1;
    run(2);
    i_Switch_1 = 1'b0;
    run(20);

    // Reset mid-CHASE.
    while (m_mode != 2) press(10, 7);
    run(11);
    i_Rst_L = 1'b0;
    run(1);
    check("midreset_leds", {o_LED_4, o_LED_3, o_LED_2, o_LED_1}, 4'b0000);
    check("midreset_mode", {2'b00, o_Mode}, 4'b0000);
    i_Rst_L = 1'b1;
    run(5);

    // Random switch activity; presses land on arbitrary prescaler phases, including tick cycles.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 8) begin
        press($urandom_range(1, 12), $urandom_range(1, 12));
      end else if (r < 12) begin
        i_Switch_2 = ~i_Switch_2;
        run($urandom_range(1, 25));
      end else if (r == 12) begin
        i_Rst_L = 1'b0;
        run($urandom_range(1, 3));
        i_Rst_L = 1'b1;
        run(2);
      end else begin
        run($urandom_range(1, 20));
      end
    end
    i_Switch_2 = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
